// File: rtl/simon_pkg.sv
// simon_pkg - shared types and constants for the Simon Says color path.
//   state_t       : sequencer FSM state encoding (3 bits, 7 states)
//   COLOR_0..3    : color codes, shared with the color display stage
//   LFSR_TAPS     : tap mask of the 8-bit Fibonacci LFSR (bits 7,5,4,3)
//   lfsrNext()    : one LFSR step, {l[6:0], parity(l & taps)}
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GAP      = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_OFF = 3'd3,
    ST_WAIT_IN  = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } state_t;

  localparam logic [1:0] COLOR_0 = 2'b00;
  localparam logic [1:0] COLOR_1 = 2'b01;
  localparam logic [1:0] COLOR_2 = 2'b10;
  localparam logic [1:0] COLOR_3 = 2'b11;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsrNext(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/simon_sequencer_if.sv
// simon_sequencer_if - player/display side signals of the sequencer.
//   start          : single-cycle pulse, begin a new game
//   btn_valid      : single-cycle pulse, a player press is present
//   btn_color      : color of the press
//   color_out      : color being displayed (00 when color_valid=0)
//   color_valid    : a sequence color is being displayed
//   awaiting_input : sequencer waits for player presses
//   level          : current round length (0 in IDLE)
//   win / lose     : game outcome, held until the next start
// master drives the inputs (debouncers / bench), slave is the sequencer.
interface simon_sequencer_if #(
  parameter int MAX_LEN = 16
);
  localparam int LEVEL_W = $clog2(MAX_LEN + 1);

  logic               start;
  logic               btn_valid;
  logic [1:0]         btn_color;
  logic [1:0]         color_out;
  logic               color_valid;
  logic               awaiting_input;
  logic [LEVEL_W-1:0] level;
  logic               win;
  logic               lose;

  modport master (
    output start, btn_valid, btn_color,
    input  color_out, color_valid, awaiting_input, level, win, lose
  );

  modport slave (
    input  start, btn_valid, btn_color,
    output color_out, color_valid, awaiting_input, level, win, lose
  );

endinterface

// File: rtl/simon_lfsr8.sv
// simon_lfsr8 - 8-bit Fibonacci LFSR that advances only when told to.
//   clk     : system clock
//   reset   : asynchronous active-high, loads SEED (must be nonzero)
//   i_step  : advance one step on this clock edge
//   o_value : current LFSR contents
module simon_lfsr8 import simon_pkg::*; #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_step,
  output logic [7:0] o_value
);

  logic [7:0] r_lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else if (i_step) begin
      r_lfsr <= lfsrNext(r_lfsr);
    end
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/simon_sequencer.sv
// simon_sequencer - Simon Says game-sequence controller.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : simon_sequencer_if.slave (start/button inputs,
//                color display and game status outputs)
// Builds the color sequence one LFSR step per round, plays it back with
// ON_TICKS shown / OFF_TICKS blank cycles per color, then checks presses.
// All outputs decode registered state only.
module simon_sequencer import simon_pkg::*; #(
  parameter int         MAX_LEN   = 16,
  parameter int         ON_TICKS  = 50,
  parameter int         OFF_TICKS = 25,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input logic              clk,
  input logic              reset,
  simon_sequencer_if.slave bus
);

  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  state_t          r_state, w_stateNext;
  logic [LW-1:0]   r_level, w_levelNext;
  logic [LW-1:0]   r_idx, w_idxNext;
  logic [LW-1:0]   w_lastIdx;
  logic [TW-1:0]   r_timer, w_timerNext;
  logic            w_append;
  logic [IW-1:0]   w_wrIdx;
  logic [7:0]      w_lfsr;
  logic [1:0]      w_memAtIdx;
  logic [1:0]      r_mem [MAX_LEN];
  logic            w_unusedLfsrBits;

  simon_lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .i_step  (w_append),
    .o_value (w_lfsr)
  );

  // Only the two low LFSR bits become colors; the rest just feed the LFSR.
  assign w_unusedLfsrBits = ^w_lfsr[7:2];

  assign w_lastIdx  = r_level - LW'(1);
  assign w_memAtIdx = r_mem[r_idx[IW-1:0]];

  // Next-state logic. Every transition clears the timer; an append writes
  // the current LFSR color at the new last position and steps the LFSR.
  always_comb begin
    w_stateNext = r_state;
    w_levelNext = r_level;
    w_idxNext   = r_idx;
    w_timerNext = r_timer;
    w_append    = 1'b0;
    w_wrIdx     = r_level[IW-1:0];

    case (r_state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        // A restart from WIN/LOSE behaves as if level were already 0.
        if (bus.start) begin
          w_append    = 1'b1;
          w_wrIdx     = '0;
          w_levelNext = LW'(1);
          w_idxNext   = '0;
          w_timerNext = '0;
          w_stateNext = ST_GAP;
        end
      end

      ST_GAP: begin
        if (r_timer == TW'(OFF_TICKS - 1)) begin
          w_idxNext   = '0;
          w_timerNext = '0;
          w_stateNext = ST_SHOW_ON;
        end else begin
          w_timerNext = r_timer + TW'(1);
        end
      end

      ST_SHOW_ON: begin
        if (r_timer == TW'(ON_TICKS - 1)) begin
          w_timerNext = '0;
          w_stateNext = ST_SHOW_OFF;
        end else begin
          w_timerNext = r_timer + TW'(1);
        end
      end

      ST_SHOW_OFF: begin
        if (r_timer == TW'(OFF_TICKS - 1)) begin
          w_timerNext = '0;
          if (r_idx == w_lastIdx) begin
            w_idxNext   = '0;
            w_stateNext = ST_WAIT_IN;
          end else begin
            w_idxNext   = r_idx + LW'(1);
            w_stateNext = ST_SHOW_ON;
          end
        end else begin
          w_timerNext = r_timer + TW'(1);
        end
      end

      ST_WAIT_IN: begin
        if (bus.btn_valid) begin
          if (bus.btn_color != w_memAtIdx) begin
            w_timerNext = '0;
            w_stateNext = ST_LOSE;
          end else if (r_idx != w_lastIdx) begin
            w_idxNext = r_idx + LW'(1);
          end else if (r_level == LW'(MAX_LEN)) begin
            w_timerNext = '0;
            w_stateNext = ST_WIN;
          end else begin
            w_append    = 1'b1;
            w_levelNext = r_level + LW'(1);
            w_idxNext   = '0;
            w_timerNext = '0;
            w_stateNext = ST_GAP;
          end
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_level <= '0;
      r_idx   <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_stateNext;
      r_level <= w_levelNext;
      r_idx   <= w_idxNext;
      r_timer <= w_timerNext;
    end
  end

  // Sequence memory has no reset: entries are always written before read.
  always_ff @(posedge clk) begin
    if (w_append) begin
      r_mem[w_wrIdx] <= w_lfsr[1:0];
    end
  end

  assign bus.color_valid    = (r_state == ST_SHOW_ON);
  assign bus.color_out      = (r_state == ST_SHOW_ON) ? w_memAtIdx : COLOR_0;
  assign bus.awaiting_input = (r_state == ST_WAIT_IN);
  assign bus.win            = (r_state == ST_WIN);
  assign bus.lose           = (r_state == ST_LOSE);
  assign bus.level          = r_level;

endmodule
